// File: rtl/mult_share_pkg.sv
// Shared types and sizing for the two-port time-shared multiplier.
package mult_share_pkg;
    localparam int OP_W_DEF        = 8;
    localparam int PROD_W_DEF      = 2 * OP_W_DEF;
    localparam int MAX_PIPE_STAGES = 4;
    localparam int CNT_W           = 16;

    typedef logic port_id_t;

    function automatic int prod_width(input int op_w);
        return 2 * op_w;
    endfunction
endpackage

// File: rtl/mult_pipe.sv
// Registered unsigned multiplier; valid and port tag travel with the data.
// Latency: PIPE_STAGES edges from input to out_*.
// Backpressure: none, accepts a new operand pair every cycle.
module mult_pipe
    import mult_share_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int PIPE_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  port_id_t                  in_tag,
    input  logic [OP_W-1:0]           in_a,
    input  logic [OP_W-1:0]           in_b,
    output logic                      out_valid,
    output port_id_t                  out_tag,
    output logic [prod_width(OP_W)-1:0] out_product
);
    localparam int PROD_W = prod_width(OP_W);
    // Out-of-range depths are clamped so the pipeline always elaborates.
    localparam int STAGES = (PIPE_STAGES < 1) ? 1 :
                            ((PIPE_STAGES > MAX_PIPE_STAGES) ? MAX_PIPE_STAGES : PIPE_STAGES);

    logic [STAGES-1:0] vld;
    port_id_t [STAGES-1:0] tag;
    logic [PROD_W-1:0] prod [STAGES];
    logic [PROD_W-1:0] prod_in;

    assign prod_in = PROD_W'(in_a) * PROD_W'(in_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            tag <= '0;
            for (int i = 0; i < STAGES; i++) prod[i] <= '0;
        end else begin
            vld[0]  <= in_valid;
            tag[0]  <= in_tag;
            prod[0] <= prod_in;
            for (int i = 1; i < STAGES; i++) begin
                vld[i]  <= vld[i-1];
                tag[i]  <= tag[i-1];
                prod[i] <= prod[i-1];
            end
        end
    end

    assign out_valid   = vld[STAGES-1];
    assign out_tag     = tag[STAGES-1];
    assign out_product = prod[STAGES-1];
endmodule

// File: rtl/mult_share_arb.sv
// Two requesters round-robin share one pipelined multiplier; optional grant counters via MULT_SHARE_ARB_STATS_EN.
// Latency: product in result register PIPE_STAGES edges after accept.
// Backpressure: a held result blocks only its own port (one op outstanding per port).
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [OP_W-1:0]        req0_a,
    input  logic [OP_W-1:0]        req0_b,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic [2*OP_W-1:0]      rsp0_product,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [OP_W-1:0]        req1_a,
    input  logic [OP_W-1:0]        req1_b,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [2*OP_W-1:0]      rsp1_product,
    output logic                   busy
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]       grant_cnt0,
    output logic [CNT_W-1:0]       grant_cnt1
`endif
);
    localparam int PROD_W = 2 * OP_W;

    logic [1:0]        outstanding;
    port_id_t          last_grant;
    logic              cand0, cand1, grant0, grant1;
    logic              pipe_vld;
    port_id_t          pipe_tag;
    logic [PROD_W-1:0] pipe_prod;
    logic [OP_W-1:0]   mux_a, mux_b;

    // Grants are forced low while reset is asserted so ready reads 0 during reset.
    always_comb begin
        cand0  = req0_valid & ~outstanding[0] & rst_n;
        cand1  = req1_valid & ~outstanding[1] & rst_n;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (cand0 && cand1) begin
            if (last_grant == 1'b1) grant0 = 1'b1;
            else                    grant1 = 1'b1;
        end else begin
            grant0 = cand0;
            grant1 = cand1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mux_a      = grant1 ? req1_a : req0_a;
    assign mux_b      = grant1 ? req1_b : req0_b;

    mult_pipe #(
        .OP_W        (OP_W),
        .PIPE_STAGES (PIPE_STAGES)
    ) u_mult (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (grant0 | grant1),
        .in_tag      (port_id_t'(grant1)),
        .in_a        (mux_a),
        .in_b        (mux_b),
        .out_valid   (pipe_vld),
        .out_tag     (pipe_tag),
        .out_product (pipe_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding  <= 2'b00;
            last_grant   <= 1'b1;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_product <= '0;
            rsp1_product <= '0;
        end else begin
            if (grant0) begin
                outstanding[0] <= 1'b1;
                last_grant     <= 1'b0;
            end else if (rsp0_valid && rsp0_ready) begin
                outstanding[0] <= 1'b0;
            end
            if (grant1) begin
                outstanding[1] <= 1'b1;
                last_grant     <= 1'b1;
            end else if (rsp1_valid && rsp1_ready) begin
                outstanding[1] <= 1'b0;
            end
            // A port's result register is always empty when its product arrives.
            if (pipe_vld && pipe_tag == 1'b0) begin
                rsp0_valid   <= 1'b1;
                rsp0_product <= pipe_prod;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (pipe_vld && pipe_tag == 1'b1) begin
                rsp1_valid   <= 1'b1;
                rsp1_product <= pipe_prod;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

    assign busy = outstanding[0] | outstanding[1];

`ifdef MULT_SHARE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (grant1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed and random checks of mult_share_arb against a queue-based product/grant model.
module tb_mult_share_arb;
    localparam int OP_W = 8;
    localparam int P    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [OP_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [2*OP_W-1:0] rsp0_product, rsp1_product;
    logic            busy;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1;
`endif

    int errors = 0;
    int checks = 0;
    int unsigned exp_q0[$];
    int unsigned exp_q1[$];
    int pops[2] = '{0, 0};
    int model_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    mult_share_arb #(.OP_W(OP_W), .PIPE_STAGES(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_product (rsp0_product),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_product (rsp1_product),
        .busy         (busy)
`ifdef MULT_SHARE_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each accept queues a*b for its port; each pop must match the head.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            model_cnt = '{0, 0};
        end else begin
            chk("single_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                exp_q0.push_back(int'(req0_a) * int'(req0_b));
                if (model_cnt[0] < 65535) model_cnt[0]++;
            end
            if (req1_valid && req1_ready) begin
                exp_q1.push_back(int'(req1_a) * int'(req1_b));
                if (model_cnt[1] < 65535) model_cnt[1]++;
            end
            if (rsp0_valid && rsp0_ready) begin
                chk("rsp0_expected", {31'd0, exp_q0.size() > 0}, 32'd1);
                if (exp_q0.size() > 0) chk("rsp0_product", rsp0_product, exp_q0.pop_front());
                pops[0]++;
            end
            if (rsp1_valid && rsp1_ready) begin
                chk("rsp1_expected", {31'd0, exp_q1.size() > 0}, 32'd1);
                if (exp_q1.size() > 0) chk("rsp1_product", rsp1_product, exp_q1.pop_front());
                pops[1]++;
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, n, n1, p0, p1, ng, prev, g;
        int gcnt[2];
        logic acc;
        logic [2*OP_W-1:0] held, first_exp;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_product", rsp0_product, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 alone: 13*11, latency and busy window
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd13; req0_b = 8'd11;
        #1;
        chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        busy_cnt = 0;
        for (int j = 1; j <= P + 3; j++) begin
            @(negedge clk);
            if (j == 1) req0_valid = 1'b0;
            #1;
            busy_cnt += int'(busy);
            chk("t1_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, j == P + 1});
            chk("t1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
            if (j == P + 1) chk("t1_product", rsp0_product, 32'd143);
        end
        chk("t1_busy_cycles", busy_cnt, P + 1);
        wait_idle("t1_idle");

        // Both valid out of reset: port 0 first, then port 1
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd255;
        req1_valid = 1'b1; req1_a = 8'd0;   req1_b = 8'd200;
        #1;
        chk("t2_rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("t2_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pops[0]; p1 = pops[1];
        #1;
        chk("t2_first_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t2_first_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("t2_second_ready1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_prod0", rsp0_product, 32'h0000FE01);
        chk("t2_prod1", rsp1_product, 32'd0);
        chk("t2_pops", (pops[0] - p0) * 16 + (pops[1] - p1), 32'h11);

        // Port 0 result held for many cycles while port 1 runs three ops
        rsp0_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_a = OP_W'($urandom_range(255)); req0_b = OP_W'($urandom_range(255));
        first_exp = (2*OP_W)'(req0_a) * (2*OP_W)'(req0_b);
        #1;
        chk("t3_accept0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_a = OP_W'($urandom_range(255)); req0_b = OP_W'($urandom_range(255));
        n = 0;
        while (!rsp0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_rsp0_arrive", {31'd0, rsp0_valid}, 32'd1);
        chk("t3_rsp0_value", rsp0_product, first_exp);
        held = rsp0_product;
        p1 = pops[1];
        n1 = 0; acc = 1'b0;
        req1_valid = 1'b1;
        req1_a = OP_W'($urandom_range(255)); req1_b = OP_W'($urandom_range(255));
        for (int i = 0; i < 16; i++) begin
            #1;
            if (req1_valid && req1_ready) begin
                n1++;
                acc = 1'b1;
            end
            chk("t3_req0_blocked", {31'd0, req0_ready}, 32'd0);
            chk("t3_rsp0_held_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("t3_rsp0_held_product", rsp0_product, held);
            @(negedge clk);
            if (acc) begin
                acc = 1'b0;
                req1_a = OP_W'($urandom_range(255)); req1_b = OP_W'($urandom_range(255));
                if (n1 >= 3) req1_valid = 1'b0;
            end
        end
        chk("t3_port1_accepts", n1, 3);
        chk("t3_port1_pops", pops[1] - p1, 3);
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        wait_idle("t3_idle");

        // Reset while a port-1 op sits in stage 1
        @(negedge clk);
        req1_valid = 1'b1;
        req1_a = OP_W'($urandom_range(1, 255)); req1_b = OP_W'($urandom_range(1, 255));
        #1;
        chk("t4_accept1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("t4_rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("t4_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("t4_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("t4_rst_prod0", rsp0_product, 32'd0);
        chk("t4_rst_prod1", rsp1_product, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b0;
        repeat (P + 6) begin
            @(negedge clk);
            if (rsp1_valid) acc = 1'b1;
        end
        chk("t4_no_stale_rsp1", {31'd0, acc}, 32'd0);
        p1 = pops[1];
        req1_valid = 1'b1;
        req1_a = OP_W'($urandom_range(255)); req1_b = OP_W'($urandom_range(255));
        @(negedge clk);
        req1_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_after_reset_pop", pops[1] - p1, 1);

        // Both ports continuously valid: 20 grants must alternate
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = OP_W'($urandom_range(255)); req0_b = OP_W'($urandom_range(255));
        req1_a = OP_W'($urandom_range(255)); req1_b = OP_W'($urandom_range(255));
        ng = 0; prev = -1; gcnt = '{0, 0}; n = 0;
        while (ng < 20 && n < 400) begin
            #1;
            g = req0_ready ? 0 : (req1_ready ? 1 : -1);
            if (g >= 0) begin
                if (prev >= 0) chk("t5_alternate", g, 1 - prev);
                prev = g;
                gcnt[g]++;
                ng++;
            end
            @(negedge clk);
            n++;
            if (g == 0) begin
                req0_a = OP_W'($urandom_range(255)); req0_b = OP_W'($urandom_range(255));
            end else if (g == 1) begin
                req1_a = OP_W'($urandom_range(255)); req1_b = OP_W'($urandom_range(255));
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t5_grants_port0", gcnt[0], 10);
        chk("t5_grants_port1", gcnt[1], 10);
        wait_idle("t5_idle");

`ifdef MULT_SHARE_ARB_STATS_EN
        chk("stats_cnt0", grant_cnt0, model_cnt[0]);
        chk("stats_cnt1", grant_cnt1, model_cnt[1]);
        force dut.cnt0 = 16'hFFFF;
        @(negedge clk);
        release dut.cnt0;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("stats_saturate", grant_cnt0, 32'h0000FFFF);
        wait_idle("stats_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
